// File: rtl/regfile_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_arb_pkg
// Shared defaults and helpers for the register-file write arbiter.
//   WORD_SIZE_DEF / ADDRES_DEF / NUM_REQ_DEF / CNT_W_DEF : default parameters
//   REG_ZERO    : architectural zero register (writes to it are dropped)
//   next_rr_idx : index following idx in a ring of num entries
// -----------------------------------------------------------------------------
package regfile_arb_pkg;

    localparam int WORD_SIZE_DEF = 32;
    localparam int ADDRES_DEF    = 5;
    localparam int NUM_REQ_DEF   = 3;
    localparam int CNT_W_DEF     = 16;

    localparam int REG_ZERO      = 0;

    // Round-robin successor of idx, wrapping at num.
    function automatic int next_rr_idx(input int idx, input int num);
        int nxt;
        nxt = idx + 32'sd1;
        if (nxt >= num) begin
            nxt = 32'sd0;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter for one shared resource. The search starts at the
// pointer and wraps; the first requesting index wins. The pointer moves one
// past the winner, and holds when nobody is granted.
//   clk, reset   : clock, asynchronous active-high reset
//   req_i        : request vector
//   gnt_o        : one-hot (or zero) grant, combinational
//   gnt_idx_o    : index of the granted requester
//   gnt_valid_o  : a grant is issued this cycle
// -----------------------------------------------------------------------------
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
    output logic                       gnt_valid_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] gnt_s;
    logic [IDX_W-1:0]   idx_s;
    logic [IDX_W-1:0]   cand_idx_s;
    logic               found_s;
    int                 cand_s;

    // Priority search from ptr with wrap; no grant while reset is high.
    always_comb begin
        gnt_s      = {NUM_REQ{1'b0}};
        idx_s      = {IDX_W{1'b0}};
        found_s    = 1'b0;
        cand_s     = 32'sd0;
        cand_idx_s = {IDX_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = int'(ptr_q) + k;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = IDX_W'(cand_s);
            if (!found_s && !reset && req_i[cand_idx_s]) begin
                found_s           = 1'b1;
                gnt_s[cand_idx_s] = 1'b1;
                idx_s             = cand_idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer advances past the winner, otherwise holds.
    always_comb begin
        if (found_s) begin
            ptr_d = IDX_W'(next_rr_idx(int'(idx_s), NUM_REQ));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= {IDX_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_o       = gnt_s;
    assign gnt_idx_o   = idx_s;
    assign gnt_valid_o = found_s;

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the single register-file write port among NUM_REQ writeback sources.
// One source is granted per cycle (round-robin); its write appears on the
// port one cycle later. Writes to register 0 complete the handshake but never
// raise signal_we.
//   clk, reset        : clock, asynchronous active-high reset
//   req_valid/ready   : per-source handshake (ready is combinational)
//   req_addres/data   : packed per-source destination / data
//   signal_we, addres_write, data_write : register-file write port
//   inflight_valid/addres : mirror of the output stage for hazard logic
//   contention_cnt    : saturating count of cycles with 2+ valid requests
// -----------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int ADDRES    = ADDRES_DEF,
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDRES-1:0]     req_addres,
    input  logic [NUM_REQ*WORD_SIZE-1:0]  req_data,
    output logic                          signal_we,
    output logic [ADDRES-1:0]             addres_write,
    output logic [WORD_SIZE-1:0]          data_write,
    output logic                          inflight_valid,
    output logic [ADDRES-1:0]             inflight_addres,
    output logic [CNT_W-1:0]              contention_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   gnt_s;
    logic [IDX_W-1:0]     gnt_idx_s;
    logic                 gnt_valid_s;
    logic [ADDRES-1:0]    sel_addr_s;
    logic [WORD_SIZE-1:0] sel_data_s;
    logic                 multi_s;

    logic                 we_q,   we_d;
    logic [ADDRES-1:0]    addr_q, addr_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic [CNT_W-1:0]     cnt_q,  cnt_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_valid),
        .gnt_o       (gnt_s),
        .gnt_idx_o   (gnt_idx_s),
        .gnt_valid_o (gnt_valid_s)
    );

    // Select the granted source's address and data.
    always_comb begin
        sel_addr_s = {ADDRES{1'b0}};
        sel_data_s = {WORD_SIZE{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx_s == IDX_W'(i)) begin
                sel_addr_s = req_addres[i*ADDRES +: ADDRES];
                sel_data_s = req_data[i*WORD_SIZE +: WORD_SIZE];
            end else begin
                sel_addr_s = sel_addr_s;
            end
        end
    end

    // Output stage next state; address/data hold when idle, we qualifies them.
    always_comb begin
        multi_s = ($countones(req_valid) >= 32'sd2);
        if (gnt_valid_s) begin
            we_d   = (sel_addr_s != ADDRES'(REG_ZERO));
            addr_d = sel_addr_s;
            data_d = sel_data_s;
        end else begin
            we_d   = 1'b0;
            addr_d = addr_q;
            data_d = data_q;
        end
        if (multi_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output stage and contention counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q   <= 1'b0;
            addr_q <= {ADDRES{1'b0}};
            data_q <= {WORD_SIZE{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign req_ready       = gnt_s;
    assign signal_we       = we_q;
    assign addres_write    = addr_q;
    assign data_write      = data_q;
    assign inflight_valid  = we_q;
    assign inflight_addres = addr_q;
    assign contention_cnt  = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addres;
    logic [N*DW-1:0] req_data;

    logic [N-1:0]    req_ready, req_ready_sat;
    logic            we, we_sat, iv, iv_sat;
    logic [AW-1:0]   aw, aw_sat, ia, ia_sat;
    logic [DW-1:0]   dw, dw_sat;
    logic [15:0]     cnt;
    logic [3:0]      cnt4;

    regfile_write_arbiter u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addres(req_addres), .req_data(req_data),
        .signal_we(we), .addres_write(aw), .data_write(dw),
        .inflight_valid(iv), .inflight_addres(ia),
        .contention_cnt(cnt)
    );

    regfile_write_arbiter #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_sat),
        .req_addres(req_addres), .req_data(req_data),
        .signal_we(we_sat), .addres_write(aw_sat), .data_write(dw_sat),
        .inflight_valid(iv_sat), .inflight_addres(ia_sat),
        .contention_cnt(cnt4)
    );

    always #5 clk = ~clk;

    // A requester may not withdraw an ungranted request.
    for (genvar gi = 0; gi < N; gi++) begin : g_hold
        a_hold: assert property (@(posedge clk) disable iff (reset)
            (req_valid[gi] && !req_ready[gi]) |=> req_valid[gi]);
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int            m_ptr, m_cnt, m_cnt4, last_g;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [N-1:0]  cur_v;
    logic [AW-1:0] cur_a [N];
    logic [DW-1:0] cur_d [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic load(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cur_v[i] = 1'b1;
        cur_a[i] = a;
        cur_d[i] = d;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_cnt4 = 0;
        m_we = 1'b0; m_addr = '0; m_data = '0;
    endtask

    // One clock: apply current requests, check ready, then the registered port.
    task automatic step();
        int g;
        logic [N-1:0] e_rdy;
        req_valid = cur_v;
        for (int i = 0; i < N; i++) begin
            req_addres[i*AW +: AW] = cur_a[i];
            req_data[i*DW +: DW]   = cur_d[i];
        end
        @(negedge clk);
        g = model_pick(cur_v, m_ptr);
        e_rdy = '0;
        if (g >= 0) e_rdy[g] = 1'b1;
        check("ready", 64'(req_ready), 64'(e_rdy));
        check("ready_sat", 64'(req_ready_sat), 64'(e_rdy));
        if (g >= 0) begin
            m_addr = cur_a[g];
            m_data = cur_d[g];
            m_we   = (cur_a[g] != 5'd0);
            m_ptr  = (g + 1) % N;
        end else begin
            m_we = 1'b0;
        end
        if ($countones(cur_v) >= 2) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        last_g = g;
        if (g >= 0) cur_v[g] = 1'b0;
        @(posedge clk); #1;
        check("we", 64'(we), 64'(m_we));
        check("addr", 64'(aw), 64'(m_addr));
        check("data", 64'(dw), 64'(m_data));
        check("inflight_v", 64'(iv), 64'(m_we));
        check("inflight_a", 64'(ia), 64'(m_addr));
        check("cnt", 64'(cnt), 64'(m_cnt));
        check("cnt4", 64'(cnt4), 64'(m_cnt4));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, 64'(we), 64'd0);
        check({tag, "_addr"}, 64'(aw), 64'd0);
        check({tag, "_data"}, 64'(dw), 64'd0);
        check({tag, "_iv"}, 64'(iv), 64'd0);
        check({tag, "_ia"}, 64'(ia), 64'd0);
        check({tag, "_cnt"}, 64'(cnt), 64'd0);
        check({tag, "_cnt4"}, 64'(cnt4), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        cur_v = '0;
        for (int i = 0; i < N; i++) begin
            cur_a[i] = '0;
            cur_d[i] = '0;
        end
        req_valid = '0; req_addres = '0; req_data = '0;
        model_reset();
        @(negedge clk);
        check_all_zero("reset");
        check("reset_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single source
        load(0, 5'd5, 32'hDEADBEEF);
        step();
        check("t1_gnt", 64'(last_g), 64'd0);
        check("t1_we", 64'(we), 64'd1);
        check("t1_addr", 64'(aw), 64'd5);
        check("t1_data", 64'(dw), 64'hDEADBEEF);
        step();
        check("t1_we_off", 64'(we), 64'd0);

        // Zero-register write
        load(1, 5'd0, 32'h1234);
        step();
        check("t2_gnt", 64'(last_g), 64'd1);
        check("t2_we", 64'(we), 64'd0);

        // Pointer fairness
        load(2, 5'd9, 32'hA5A5_0002);
        step();
        check("t3_gnt_a", 64'(last_g), 64'd2);
        load(0, 5'd10, 32'h0000_0010);
        load(2, 5'd11, 32'h0000_0011);
        step();
        check("t3_gnt_b", 64'(last_g), 64'd0);
        step();
        check("t3_gnt_c", 64'(last_g), 64'd2);

        // Full contention
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!cur_v[j]) load(j, 5'($urandom_range(1, 31)), $urandom);
            end
            step();
            check("t4_gnt", 64'(last_g), 64'(i % 3));
            check("t4_we", 64'(we), 64'd1);
            check("t4_cnt", 64'(cnt), 64'(i + 2));
        end

        // Reset mid-stream: move ptr to 2 with a live write on the port
        step();
        check("t5_gnt_a", 64'(last_g), 64'd0);
        step();
        check("t5_gnt_b", 64'(last_g), 64'd1);
        check("t5_we_pre", 64'(we), 64'd1);
        #2;
        reset = 1'b1;
        load(0, 5'd3, 32'h0000_0003);
        load(1, 5'd4, 32'h0000_0004);
        load(2, 5'd6, 32'h0000_0006);
        req_valid = cur_v;
        #1;
        check_all_zero("t5_rst");
        model_reset();
        @(negedge clk);
        check("t5_ready_rst", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        step();
        check("t5_gnt_post", 64'(last_g), 64'd0);

        // Saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!cur_v[j]) load(j, 5'($urandom_range(0, 31)), $urandom);
            end
            step();
        end
        check("t6_cnt4_sat", 64'(cnt4), 64'd15);
        check("t6_cnt", 64'(cnt), 64'd21);

        // Random traffic honouring the hold rule
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!cur_v[j] && ($urandom_range(0, 1) == 1)) begin
                    load(j, 5'($urandom_range(0, 31)), $urandom);
                end
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
